// File: rtl/t03_cache_mem_ctrl_if.sv
// rtl/t03_cache_mem_ctrl_if.sv - CPU-side and memory-side bus bundle for the t03 data cache controller
// Signals:
//   memRead/memWrite/addr/wdata : CPU request, held while stall=1
//   rdata/hit/stall             : CPU response
//   mem_req/mem_we/mem_addr/mem_wdata : memory request, held until mem_ack
//   mem_rdata/mem_ack           : memory response, mem_ack is a one-cycle pulse
// Modports: slave = controller view, master = CPU/memory environment view.
interface t03_cache_mem_ctrl_if;
  logic        memRead;
  logic        memWrite;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        hit;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport slave (
    input  memRead, memWrite, addr, wdata, mem_rdata, mem_ack,
    output rdata, hit, stall, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output memRead, memWrite, addr, wdata, mem_rdata, mem_ack,
    input  rdata, hit, stall, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/t03_cache_mem_ctrl.sv
// rtl/t03_cache_mem_ctrl.sv - direct-mapped one-word-per-line write-through data cache controller
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : t03_cache_mem_ctrl_if.slave (CPU request/response and memory req/ack)
// Parameter LINES (power of two, >=2) sets the number of cache lines.
module t03_cache_mem_ctrl #(
  parameter int LINES = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  t03_cache_mem_ctrl_if.slave   bus
);
  localparam int IDX  = $clog2(LINES);
  localparam int TAGW = 30 - IDX;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_WRITE = 2'd2,
    S_WDONE = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [LINES-1:0]  r_valid;
  logic [TAGW-1:0]   r_tag_arr  [LINES];
  logic [31:0]       r_data_arr [LINES];
  logic [31:0]       r_mem_addr;
  logic [31:0]       r_mem_wdata;

  logic [IDX-1:0]    w_idx;
  logic [TAGW-1:0]   w_tag;
  logic              w_hit;
  logic [IDX-1:0]    w_lat_idx;
  logic [TAGW-1:0]   w_lat_tag;
  logic              w_lat_hit;
  logic              w_stall;
  logic [31:0]       w_rdata;
  logic              w_latch_addr;
  logic              w_latch_wdata;
  logic              w_fill;
  logic              w_wr_update;
  logic              w_unused_lsb;

  // Byte offset is meaningless for a word cache.
  assign w_unused_lsb = ^bus.addr[1:0];

  assign w_idx = bus.addr[IDX+1:2];
  assign w_tag = bus.addr[31:IDX+2];
  assign w_hit = r_valid[w_idx] && (r_tag_arr[w_idx] == w_tag);

  // Array updates use the latched address so they never depend on the
  // CPU keeping its request stable across the stall.
  assign w_lat_idx = r_mem_addr[IDX+1:2];
  assign w_lat_tag = r_mem_addr[31:IDX+2];
  assign w_lat_hit = r_valid[w_lat_idx] && (r_tag_arr[w_lat_idx] == w_lat_tag);

  assign w_fill      = (r_state == S_FILL)  && bus.mem_ack;
  assign w_wr_update = (r_state == S_WRITE) && bus.mem_ack && w_lat_hit;

  always_comb begin
    w_next        = r_state;
    w_stall       = 1'b0;
    w_rdata       = 32'h0;
    w_latch_addr  = 1'b0;
    w_latch_wdata = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.memWrite) begin
          w_stall       = 1'b1;
          w_latch_addr  = 1'b1;
          w_latch_wdata = 1'b1;
          w_next        = S_WRITE;
        end else if (bus.memRead) begin
          if (w_hit) begin
            w_rdata = r_data_arr[w_idx];
          end else begin
            w_stall      = 1'b1;
            w_latch_addr = 1'b1;
            w_next       = S_FILL;
          end
        end
      end
      S_FILL: begin
        w_stall = 1'b1;
        if (bus.mem_ack) w_next = S_IDLE;
      end
      S_WRITE: begin
        w_stall = 1'b1;
        if (bus.mem_ack) w_next = S_WDONE;
      end
      S_WDONE: begin
        // One unstalled cycle lets the CPU retire the store; requests ignored.
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid     <= '0;
      r_mem_addr  <= 32'h0;
      r_mem_wdata <= 32'h0;
    end else begin
      if (w_latch_addr)  r_mem_addr  <= {bus.addr[31:2], 2'b00};
      if (w_latch_wdata) r_mem_wdata <= bus.wdata;
      if (w_fill)        r_valid[w_lat_idx] <= 1'b1;
    end
  end

  // Tag and data arrays are not cleared by reset; the valid bits guard them.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_fill) begin
        r_data_arr[w_lat_idx] <= bus.mem_rdata;
        r_tag_arr[w_lat_idx]  <= w_lat_tag;
      end else if (w_wr_update) begin
        r_data_arr[w_lat_idx] <= r_mem_wdata;
      end
    end
  end

  assign bus.hit       = w_hit;
  assign bus.stall     = w_stall;
  assign bus.rdata     = w_rdata;
  assign bus.mem_req   = (r_state == S_FILL) || (r_state == S_WRITE);
  assign bus.mem_we    = (r_state == S_WRITE);
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
endmodule

// File: tb/tb_t03_cache_mem_ctrl.sv
// tb/tb_t03_cache_mem_ctrl.sv - directed vector bench for t03_cache_mem_ctrl
module tb_t03_cache_mem_ctrl;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  t03_cache_mem_ctrl_if bus ();

  t03_cache_mem_ctrl #(.LINES(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] mrdata;
    logic        e_stall;
    logic        e_hit;
    logic [31:0] e_rdata;
    logic        e_req;
    logic        e_we;
    logic [31:0] e_maddr;
    logic [31:0] e_mwdata;
  } vec_t;

  vec_t vecs [28];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] wd, input logic ack, input logic [31:0] mrd);
    bus.memRead   = rd;
    bus.memWrite  = wr;
    bus.addr      = a;
    bus.wdata     = wd;
    bus.mem_ack   = ack;
    bus.mem_rdata = mrd;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //                rd wr addr          wdata         ack mrdata        stall hit rdata         req we maddr         mwdata
    vecs[0]  = '{L, L, 32'h0,        32'h0,        L, 32'h0,        L, L, 32'h0,        L, L, 32'h0,        32'h0};
    vecs[1]  = '{H, L, 32'h100,      32'h0,        L, 32'h0,        H, L, 32'h0,        L, L, 32'h0,        32'h0};
    vecs[2]  = '{H, L, 32'h100,      32'h0,        L, 32'h0,        H, L, 32'h0,        H, L, 32'h100,      32'h0};
    vecs[3]  = '{H, L, 32'h100,      32'h0,        L, 32'h0,        H, L, 32'h0,        H, L, 32'h100,      32'h0};
    vecs[4]  = '{H, L, 32'h100,      32'h0,        L, 32'h0,        H, L, 32'h0,        H, L, 32'h100,      32'h0};
    vecs[5]  = '{H, L, 32'h100,      32'h0,        H, 32'hDEADBEEF, H, L, 32'h0,        H, L, 32'h100,      32'h0};
    vecs[6]  = '{H, L, 32'h100,      32'h0,        L, 32'h0,        L, H, 32'hDEADBEEF, L, L, 32'h100,      32'h0};
    vecs[7]  = '{H, L, 32'h100,      32'h0,        L, 32'h0,        L, H, 32'hDEADBEEF, L, L, 32'h100,      32'h0};
    vecs[8]  = '{H, L, 32'h120,      32'h0,        L, 32'h0,        H, L, 32'h0,        L, L, 32'h100,      32'h0};
    vecs[9]  = '{H, L, 32'h120,      32'h0,        H, 32'hCAFEF00D, H, L, 32'h0,        H, L, 32'h120,      32'h0};
    vecs[10] = '{H, L, 32'h120,      32'h0,        L, 32'h0,        L, H, 32'hCAFEF00D, L, L, 32'h120,      32'h0};
    vecs[11] = '{H, L, 32'h100,      32'h0,        L, 32'h0,        H, L, 32'h0,        L, L, 32'h120,      32'h0};
    vecs[12] = '{H, L, 32'h100,      32'h0,        H, 32'hDEADBEEF, H, L, 32'h0,        H, L, 32'h100,      32'h0};
    vecs[13] = '{H, L, 32'h100,      32'h0,        L, 32'h0,        L, H, 32'hDEADBEEF, L, L, 32'h100,      32'h0};
    vecs[14] = '{L, H, 32'h100,      32'h12345678, L, 32'h0,        H, H, 32'h0,        L, L, 32'h100,      32'h0};
    vecs[15] = '{L, H, 32'h100,      32'h12345678, L, 32'h0,        H, H, 32'h0,        H, H, 32'h100,      32'h12345678};
    vecs[16] = '{L, H, 32'h100,      32'h12345678, H, 32'h0,        H, H, 32'h0,        H, H, 32'h100,      32'h12345678};
    vecs[17] = '{L, H, 32'h100,      32'h12345678, L, 32'h0,        L, H, 32'h0,        L, L, 32'h100,      32'h12345678};
    vecs[18] = '{H, L, 32'h100,      32'h0,        L, 32'h0,        L, H, 32'h12345678, L, L, 32'h100,      32'h12345678};
    vecs[19] = '{L, H, 32'h200,      32'h55AA55AA, L, 32'h0,        H, L, 32'h0,        L, L, 32'h100,      32'h12345678};
    vecs[20] = '{L, H, 32'h200,      32'h55AA55AA, H, 32'h0,        H, L, 32'h0,        H, H, 32'h200,      32'h55AA55AA};
    vecs[21] = '{L, L, 32'h200,      32'h0,        L, 32'h0,        L, L, 32'h0,        L, L, 32'h200,      32'h55AA55AA};
    vecs[22] = '{H, L, 32'h200,      32'h0,        L, 32'h0,        H, L, 32'h0,        L, L, 32'h200,      32'h55AA55AA};
    vecs[23] = '{H, L, 32'h200,      32'h0,        H, 32'h0BADF00D, H, L, 32'h0,        H, L, 32'h200,      32'h55AA55AA};
    vecs[24] = '{H, L, 32'h200,      32'h0,        L, 32'h0,        L, H, 32'h0BADF00D, L, L, 32'h200,      32'h55AA55AA};
    vecs[25] = '{H, L, 32'h100,      32'h0,        L, 32'h0,        H, L, 32'h0,        L, L, 32'h200,      32'h55AA55AA};
    vecs[26] = '{H, L, 32'h100,      32'h0,        H, 32'h12345678, H, L, 32'h0,        H, L, 32'h100,      32'h55AA55AA};
    vecs[27] = '{H, L, 32'h100,      32'h0,        L, 32'h0,        L, H, 32'h12345678, L, L, 32'h100,      32'h55AA55AA};

    drive(L, L, 32'h0, 32'h0, L, 32'h0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 28; i++) begin
      @(negedge clk);
      drive(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].ack, vecs[i].mrdata);
      #1;
      chk($sformatf("v%0d.stall", i),  {31'h0, bus.stall},   {31'h0, vecs[i].e_stall});
      chk($sformatf("v%0d.hit", i),    {31'h0, bus.hit},     {31'h0, vecs[i].e_hit});
      chk($sformatf("v%0d.rdata", i),  bus.rdata,            vecs[i].e_rdata);
      chk($sformatf("v%0d.mem_req", i), {31'h0, bus.mem_req}, {31'h0, vecs[i].e_req});
      chk($sformatf("v%0d.mem_we", i), {31'h0, bus.mem_we},  {31'h0, vecs[i].e_we});
      chk($sformatf("v%0d.mem_addr", i), bus.mem_addr,       vecs[i].e_maddr);
      chk($sformatf("v%0d.mem_wdata", i), bus.mem_wdata,     vecs[i].e_mwdata);
    end

    // Reset asserted in the second FILL cycle aborts the fill.
    @(negedge clk);
    drive(H, L, 32'h140, 32'h0, L, 32'h0);
    #1;
    chk("rf.c0_stall", {31'h0, bus.stall}, 32'h1);
    chk("rf.c0_hit",   {31'h0, bus.hit},   32'h0);
    @(negedge clk);
    #1;
    chk("rf.c1_req",   {31'h0, bus.mem_req}, 32'h1);
    chk("rf.c1_addr",  bus.mem_addr,         32'h140);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rf.c2_req",   {31'h0, bus.mem_req}, 32'h1);
    @(negedge clk);
    rst = 1'b0;
    drive(L, L, 32'h140, 32'h0, H, 32'hFFFFFFFF);
    #1;
    chk("rf.post_req",   {31'h0, bus.mem_req}, 32'h0);
    chk("rf.post_addr",  bus.mem_addr,         32'h0);
    chk("rf.post_stall", {31'h0, bus.stall},   32'h0);
    @(negedge clk);
    drive(H, L, 32'h140, 32'h0, L, 32'h0);
    #1;
    chk("rf.reread_hit",   {31'h0, bus.hit},   32'h0);
    chk("rf.reread_stall", {31'h0, bus.stall}, 32'h1);
    @(negedge clk);
    drive(L, L, 32'h0, 32'h0, L, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // memRead and memWrite together behave as a store.
    @(negedge clk);
    drive(H, H, 32'h180, 32'hA5A5A5A5, L, 32'h0);
    #1;
    chk("rw.c0_stall", {31'h0, bus.stall},   32'h1);
    chk("rw.c0_req",   {31'h0, bus.mem_req}, 32'h0);
    @(negedge clk);
    #1;
    chk("rw.req",   {31'h0, bus.mem_req}, 32'h1);
    chk("rw.we",    {31'h0, bus.mem_we},  32'h1);
    chk("rw.addr",  bus.mem_addr,         32'h180);
    chk("rw.wdata", bus.mem_wdata,        32'hA5A5A5A5);
    bus.mem_ack = H;
    @(negedge clk);
    bus.mem_ack = L;
    #1;
    chk("rw.wdone_stall", {31'h0, bus.stall},   32'h0);
    chk("rw.wdone_req",   {31'h0, bus.mem_req}, 32'h0);

    // A stray ack in IDLE must not start anything.
    @(negedge clk);
    drive(L, L, 32'h0, 32'h0, H, 32'h0);
    #1;
    chk("ia.stall", {31'h0, bus.stall}, 32'h0);
    @(negedge clk);
    bus.mem_ack = L;
    #1;
    chk("ia.req",   {31'h0, bus.mem_req}, 32'h0);
    chk("ia.we",    {31'h0, bus.mem_we},  32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/t03_cache_mem_ctrl.md
# t03_cache_mem_ctrl

Memory-side controller for the t03 data cache. It holds a direct-mapped, one-word-per-line cache (tag, valid and data arrays). Read hits are answered in the same cycle. On a read miss it stalls the CPU, fetches the word from memory over a req/ack handshake and fills the line. Writes are write-through: every store goes to memory and updates the line only on a hit (no write-allocate).

## Interface

Parameters:
- LINES, 8: number of cache lines; power of two, ≥2. IDX = log2(LINES).

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- memRead  input  1  CPU load request; held while stall=1
- memWrite  input  1  CPU store request; held while stall=1
- addr  input  32  CPU byte address; addr[1:0] ignored
- wdata  input  32  CPU store data
- rdata  output  32  load data to the CPU data DFF
- hit  output  1  combinational tag match and valid for the current addr
- stall  output  1  freeze CPU; request must be held unchanged
- mem_req  output  1  memory transaction active
- mem_we  output  1  1=write, 0=read; valid while mem_req=1
- mem_addr  output  32  word-aligned address {addr[31:2],2'b00}, latched
- mem_wdata  output  32  latched store data
- mem_rdata  input  32  memory read data, valid when mem_ack=1
- mem_ack  input  1  one-cycle completion pulse from memory

## Operation

- Address split: index = addr[IDX+1:2], tag = addr[31:IDX+2].
- hit = valid[index] && tag_arr[index]==tag. It is computed in every state.
- FSM states: IDLE, FILL, WRITE, WDONE. All transitions occur on rising clk.
- IDLE behaviour:
  - memWrite=1 (takes priority over memRead): stall=1, latch addr/wdata, go to WRITE.
  - memRead=1 and hit: rdata=data_arr[index], stall=0, stay in IDLE.
  - memRead=1 and miss: stall=1, latch addr, go to FILL.
  - No request: stall=0, rdata=0.
- FILL: mem_req=1, mem_we=0, stall=1. On mem_ack, write mem_rdata into data_arr[index], tag into tag_arr[index], set valid, go to IDLE. The held request then hits in IDLE.
- WRITE: mem_req=1, mem_we=1, stall=1. On mem_ack:
  - if the latched address hits, overwrite data_arr[index] with wdata;
  - go to WDONE.
- WDONE: stall=0 for exactly one cycle so the CPU retires the store. memRead/memWrite are ignored in this state. Go to IDLE.
- Miss eviction overwrites the line unconditionally; nothing is dirty.
- mem_ack in IDLE or WDONE is ignored.
- mem_addr/mem_wdata hold their latched values until the next transaction. mem_req is decoded from state only (Moore).

## Timing

- Reset (rst=1 at a clk edge): state=IDLE, all valid bits=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0. With no request, rdata=0 and stall=0. Data and tag arrays are not cleared.
- Read hit: 0 extra cycles; rdata is valid in the same cycle as the request.
- Read miss:
  - cycle 0: stall=1, mem_req=0;
  - cycle 1 onward: mem_req=1 until the ack cycle inclusive;
  - the cycle after ack: IDLE, hit=1, stall=0, rdata is valid.
  - Total = N+2 cycles for an ack N cycles after mem_req rises (N≥0; ack in the same cycle mem_req rises counts as N=0).
- Write:
  - cycle 0: stall=1;
  - WRITE lasts until ack;
  - WDONE has stall=0;
  - a new request is accepted the following cycle.
- Reset during FILL or WRITE:
  - the transaction is aborted and mem_req=0 from the next cycle;
  - no fill occurs and no array update occurs;
  - a late mem_ack is ignored.
- memRead and memWrite asserted together are treated as a write.

## Test plan

- Reset, then read 0x100: stall=1 and mem_req=0 in cycle 0, then mem_req=1 with mem_addr=0x100. Ack 3 cycles later with mem_rdata=0xDEADBEEF. The next cycle shows hit=1, stall=0, rdata=0xDEADBEEF.
- Read 0x100 again: hit=1 and rdata=0xDEADBEEF in the same cycle; mem_req stays 0.
- Read 0x120 with LINES=8 (same index 0): miss and fill with 0xCAFEF00D. A following read of 0x100 then misses and issues mem_addr=0x100.
- Write 0x100 with wdata=0x12345678 after it has been cached: mem_req=1, mem_we=1, mem_wdata=0x12345678. After ack, WDONE shows stall=0 for one cycle. A read of 0x100 then hits with 0x12345678.
- Write miss to 0x200 with 0x55AA55AA: the memory write completes, but a following read of 0x200 misses (no allocate).
- Assert rst in FILL cycle 2: mem_req=0 on the next cycle and a late ack is ignored. A read of the same address misses. Also, memRead=memWrite=1 must produce mem_we=1.
